parity_scan_controller: RTL and testbench
=========================================

Name: parity_scan_controller

Overview:
- Sequencer for the two-bank 8x8 data/parity memory and its parity checker.
- On a start request, the block walks every address across both banks: bank select is address bit 3, word index is bits 2:0.
- It checks each stored parity bit against the recomputed parity, counts mismatches and records the first failing address.
- It replaces the free-running ripple counter as the address source, adding a start/busy/done handshake and an optional stop-on-error.

Parameters:
- ADDR_W, 4, address width; the scan covers 0 .. 2**ADDR_W-1.
- DATA_W, 8, memory word width.
- CNT_W, 5, error counter width; saturates at 2**CNT_W-1.

Ports:
- clock  input  1  system clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  scan request; sampled only in IDLE.
- stop_on_error  input  1  when 1, the scan ends at the first mismatch; sampled together with start.
- mem_addr  output  ADDR_W  registered address to the memory fetch path.
- mem_data  input  DATA_W  word read from mem_addr; valid one cycle after the address is presented.
- mem_parity  input  1  stored parity bit for mem_addr; same timing as mem_data.
- busy  output  1  high from the cycle after start is accepted until DONE is exited.
- done  output  1  one-cycle pulse at scan end.
- err_pulse  output  1  one-cycle pulse per detected mismatch.
- err_addr  output  ADDR_W  address of the mismatch flagged by err_pulse; holds its last value.
- err_count  output  CNT_W  number of mismatches in the current/last scan.
- first_err_valid  output  1  at least one mismatch seen in the current/last scan.
- first_err_addr  output  ADDR_W  address of the first mismatch; 0 if none.

Behaviour:
- Mismatch rule: mem_parity != ^mem_data (XOR reduction).
- Reset (async, immediate): state = IDLE; every output = 0 (mem_addr, busy, done, err_pulse, err_addr, err_count, first_err_valid, first_err_addr). Applies mid-scan too; the scan is abandoned with no done pulse.
- States: IDLE, ISSUE, CHECK, DONE.
- IDLE:
  - start = 1 -> ISSUE.
  - On entry to ISSUE: mem_addr <= 0; err_count, first_err_valid and first_err_addr cleared; stop_on_error latched; busy <= 1.
- ISSUE: mem_addr held for one cycle (memory read latency) -> CHECK.
- CHECK: mem_data/mem_parity sampled with mem_addr unchanged.
  - On mismatch:
    - err_pulse = 1 and err_addr = mem_addr in the next cycle.
    - err_count incremented, saturating.
    - If first_err_valid = 0: first_err_addr <= mem_addr and first_err_valid <= 1.
  - Next state:
    - Mismatch with latched stop_on_error = 1 -> DONE.
    - Else mem_addr = all-ones -> DONE.
    - Else mem_addr <= mem_addr + 1 -> ISSUE.
- DONE:
  - done = 1 for exactly one cycle; busy <= 0 on exit -> IDLE.
  - mem_addr holds the last checked address.
  - Results hold until the next accepted start.
- Timing: 2 cycles per address. A full 16-address scan asserts done 33 cycles after the start edge (first ISSUE cycle counted as 1).
- start while busy (ISSUE/CHECK/DONE) is ignored. start held high continuously relaunches a scan after each DONE, with one IDLE cycle between scans.
- err_pulse is registered: it asserts the cycle after the failing CHECK, which may coincide with done.
- No address wrap within a scan; the address increments only in CHECK.

Decomposition:
- Shared package:
  - State encoding constants: IDLE = 2'd0, ISSUE = 2'd1, CHECK = 2'd2, DONE = 2'd3.
  - ADDR_W/DATA_W defaults.
  - The parity function (XOR reduction of a DATA_W word), shared with the standalone parity checker.
- One natural sub-module: parity_err_tracker.
  - Inputs: sample strobe, mismatch, address, clear.
  - Owns: saturating counter, first-error capture, err_pulse/err_addr registers.
- The FSM and address register stay in the top.

Test Plan:
- Reset mid-scan:
  - Assert reset during CHECK at address 5 -> within the same cycle all outputs are 0 and state is IDLE.
  - No done pulse; the next start scans from 0.
- Full scan, stop_on_error = 0:
  - Bench memory: bank0 data 1F,31,53,75,97,B9,DB,FD with parity all 1; bank1 data 00,22,44,66,88,AA,CC,EE with parity all 0.
  - Expected: err_pulse with err_addr 2 then 6; err_count = 2; first_err_valid = 1; first_err_addr = 2; done 33 cycles after start; mem_addr visits 0..15 in order, 2 cycles each.
- stop_on_error = 1, same memory:
  - Expected: scan ends after address 2; err_count = 1; first_err_addr = 2; done 7 cycles after start; mem_addr never exceeds 2.
- Clean memory (all parity bits consistent):
  - Expected: err_count = 0; first_err_valid = 0; first_err_addr = 0; no err_pulse; done at cycle 33.
- start handshake:
  - Pulse start again at cycle 10 of a scan -> ignored, single done at cycle 33.
  - Hold start high -> second scan begins 2 cycles after done; results cleared at its start.
- Saturation (CNT_W = 2):
  - Every parity bit inverted -> err_count reaches 3 and stays at 3.
  - 16 err_pulses still emitted; first_err_addr = 0.

Source files
------------

// File: rtl/parity_scan_controller_pkg.sv
// Shared definitions for the parity scan sequencer: state encoding, default widths
// and the parity function also used by the standalone parity checker.
package parity_scan_controller_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 5;

    // Widest word the shared parity function accepts; narrower words are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int PAR_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    function automatic logic parity_of(input logic [PAR_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/parity_scan_controller_tracker.sv
// Mismatch bookkeeping for one scan: saturating error counter, first-failure capture
// and the registered per-mismatch pulse/address.
module parity_err_tracker #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              sample,
    input  logic              mismatch,
    input  logic [ADDR_W-1:0] addr,
    output logic              err_pulse,
    output logic [ADDR_W-1:0] err_addr,
    output logic [CNT_W-1:0]  err_count,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr
);

    logic              err_pulse_reg;
    logic [ADDR_W-1:0] err_addr_reg;
    logic [CNT_W-1:0]  err_count_reg;
    logic              first_err_valid_reg;
    logic [ADDR_W-1:0] first_err_addr_reg;

    logic hit;
    assign hit = sample && mismatch;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_pulse_reg       <= 1'b0;
            err_addr_reg        <= '0;
            err_count_reg       <= '0;
            first_err_valid_reg <= 1'b0;
            first_err_addr_reg  <= '0;
        end else begin
            err_pulse_reg <= 1'b0;
            if (clear) begin
                // err_addr is deliberately left alone: it holds the last flagged address
                err_count_reg       <= '0;
                first_err_valid_reg <= 1'b0;
                first_err_addr_reg  <= '0;
            end else if (hit) begin
                err_pulse_reg <= 1'b1;
                err_addr_reg  <= addr;
                if (err_count_reg != {CNT_W{1'b1}}) begin
                    err_count_reg <= err_count_reg + CNT_W'(1);
                end
                if (!first_err_valid_reg) begin
                    first_err_valid_reg <= 1'b1;
                    first_err_addr_reg  <= addr;
                end
            end
        end
    end

    assign err_pulse       = err_pulse_reg;
    assign err_addr        = err_addr_reg;
    assign err_count       = err_count_reg;
    assign first_err_valid = first_err_valid_reg;
    assign first_err_addr  = first_err_addr_reg;

endmodule

// File: rtl/parity_scan_controller.sv
// Walks every address of the two-bank data/parity memory (bank = addr[3], word = addr[2:0]),
// two cycles per address, and reports parity mismatches through a start/busy/done handshake.
module parity_scan_controller
    import parity_scan_controller_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop_on_error,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_parity,
    output logic              busy,
    output logic              done,
    output logic              err_pulse,
    output logic [ADDR_W-1:0] err_addr,
    output logic [CNT_W-1:0]  err_count,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr
);

    scan_state_t       state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              stop_on_error_reg;
    logic              busy_reg;
    logic              done_reg;

    logic mismatch;
    logic last_addr;
    logic scan_start;
    logic check_strobe;

    assign mismatch     = mem_parity != parity_of(PAR_MAX_W'(mem_data));
    assign last_addr    = addr_reg == {ADDR_W{1'b1}};
    assign scan_start   = (state_reg == IDLE) && start;
    assign check_strobe = state_reg == CHECK;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            addr_reg          <= '0;
            stop_on_error_reg <= 1'b0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        addr_reg          <= '0;
                        stop_on_error_reg <= stop_on_error;
                        busy_reg          <= 1'b1;
                        state_reg         <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Address is held one cycle so the memory read can land before CHECK.
                    state_reg <= CHECK;
                end
                CHECK: begin
                    if ((mismatch && stop_on_error_reg) || last_addr) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        addr_reg  <= addr_reg + ADDR_W'(1);
                        state_reg <= ISSUE;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    parity_err_tracker #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_tracker (
        .clock           (clock),
        .reset           (reset),
        .clear           (scan_start),
        .sample          (check_strobe),
        .mismatch        (mismatch),
        .addr            (addr_reg),
        .err_pulse       (err_pulse),
        .err_addr        (err_addr),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr)
    );

    assign mem_addr = addr_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_parity_scan_controller.sv
// Directed bench for parity_scan_controller: a registered two-bank memory model feeds
// the main instance (CNT_W=5) and a second instance with a 2-bit counter.
module tb_parity_scan_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop_on_error = 1'b0;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_parity;
    logic       busy, done, err_pulse, first_err_valid;
    logic [3:0] err_addr, first_err_addr;
    logic [4:0] err_count;

    logic       start_s = 1'b0;
    logic       stop_s = 1'b0;
    logic [3:0] mem_addr_s;
    logic [7:0] mem_data_s;
    logic       mem_parity_s;
    logic       busy_s, done_s, err_pulse_s, first_err_valid_s;
    logic [3:0] err_addr_s, first_err_addr_s;
    logic [1:0] err_count_s;

    logic [7:0] data_mem [16];
    logic       par_mem  [16];

    int checks = 0;
    int errors = 0;

    int         done_cyc;
    int         addr_bad;
    int         max_addr;
    logic [3:0] err_q [$];

    always #5 clock = ~clock;

    // One-cycle read latency: data for an address is visible the cycle after it is presented.
    always_ff @(posedge clock) begin
        mem_data     <= data_mem[mem_addr];
        mem_parity   <= par_mem[mem_addr];
        mem_data_s   <= data_mem[mem_addr_s];
        mem_parity_s <= ~par_mem[mem_addr_s];
    end

    parity_scan_controller #(.ADDR_W(4), .DATA_W(8), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .start(start), .stop_on_error(stop_on_error),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_parity(mem_parity),
        .busy(busy), .done(done), .err_pulse(err_pulse), .err_addr(err_addr),
        .err_count(err_count), .first_err_valid(first_err_valid), .first_err_addr(first_err_addr)
    );

    parity_scan_controller #(.ADDR_W(4), .DATA_W(8), .CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .start(start_s), .stop_on_error(stop_s),
        .mem_addr(mem_addr_s), .mem_data(mem_data_s), .mem_parity(mem_parity_s),
        .busy(busy_s), .done(done_s), .err_pulse(err_pulse_s), .err_addr(err_addr_s),
        .err_count(err_count_s), .first_err_valid(first_err_valid_s), .first_err_addr(first_err_addr_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch a scan on the main instance and follow it cycle by cycle (cycle 1 = first ISSUE)
    // until done; n_addr is the number of addresses the scan is expected to visit.
    task automatic run_scan(input logic soe, input int pulse_at, input bit hold, input int n_addr);
        int exp_addr;
        err_q.delete();
        done_cyc = 0;
        addr_bad = 0;
        max_addr = 0;
        @(negedge clock);
        start = 1'b1;
        stop_on_error = soe;
        @(negedge clock);
        if (!hold) start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (err_pulse === 1'b1) err_q.push_back(err_addr);
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            exp_addr = (c <= 2 * n_addr) ? (c - 1) / 2 : n_addr - 1;
            if (mem_addr !== 4'(exp_addr)) addr_bad++;
            if (busy !== 1'b1) addr_bad++;
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (c == pulse_at) start = 1'b1;
            else if (!hold) start = 1'b0;
            @(negedge clock);
        end
        $display("scan soe=%0d: done at cycle %0d, %0d err pulses, err_count=%0d first=%0d/%0h",
                 soe, done_cyc, err_q.size(), err_count, first_err_valid, first_err_addr);
    endtask

    initial begin
        int quiet_bad;
        int pulses_s;
        int drop_s;
        int done_s_cyc;
        bit saw3;
        logic [7:0] bank0 [8];
        logic [7:0] bank1 [8];
        bank0 = '{8'h1F, 8'h31, 8'h53, 8'h75, 8'h97, 8'hB9, 8'hDB, 8'hFD};
        bank1 = '{8'h00, 8'h22, 8'h44, 8'h66, 8'h88, 8'hAA, 8'hCC, 8'hEE};
        for (int i = 0; i < 8; i++) begin
            data_mem[i]     = bank0[i];
            par_mem[i]      = 1'b1;
            data_mem[i + 8] = bank1[i];
            par_mem[i + 8]  = 1'b0;
        end

        // Reset state
        #12;
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_first_err_valid", first_err_valid, 0);
        $display("reset: mem_addr=%0h busy=%0d done=%0d", mem_addr, busy, done);
        @(negedge clock);
        reset = 1'b0;

        // Reset during CHECK at address 5 (cycle 12 of the scan)
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (11) @(negedge clock);
        chk("midscan_addr", mem_addr, 5);
        chk("midscan_first_err_valid", first_err_valid, 1);
        reset = 1'b1;
        #1;
        chk("async_rst_outputs", {mem_addr, busy, done, err_pulse, err_addr, err_count,
                                  first_err_valid, first_err_addr}, 0);
        $display("mid-scan reset: busy=%0d err_count=%0d", busy, err_count);
        @(negedge clock);
        reset = 1'b0;
        quiet_bad = 0;
        repeat (4) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0) quiet_bad++;
        end
        chk("after_rst_no_done", quiet_bad, 0);

        // Full scan, errors at 2 and 6
        run_scan(1'b0, 0, 1'b0, 16);
        chk("full_done_cycle", done_cyc, 33);
        chk("full_addr_trace", addr_bad, 0);
        chk("full_pulse_count", err_q.size(), 2);
        if (err_q.size() == 2) begin
            chk("full_err_addr0", err_q[0], 2);
            chk("full_err_addr1", err_q[1], 6);
        end
        chk("full_err_count", err_count, 2);
        chk("full_first_valid", first_err_valid, 1);
        chk("full_first_addr", first_err_addr, 2);
        @(negedge clock);
        chk("full_done_one_cycle", {done, busy}, 0);

        // Stop on first error
        run_scan(1'b1, 0, 1'b0, 3);
        stop_on_error = 1'b0;
        chk("soe_done_cycle", done_cyc, 7);
        chk("soe_addr_trace", addr_bad, 0);
        chk("soe_max_addr", max_addr, 2);
        chk("soe_pulse_count", err_q.size(), 1);
        chk("soe_err_count", err_count, 1);
        chk("soe_first_addr", first_err_addr, 2);
        chk("soe_first_valid", first_err_valid, 1);

        // start held high: relaunch with one IDLE cycle, results cleared
        run_scan(1'b0, 0, 1'b1, 16);
        chk("hold_done_cycle", done_cyc, 33);
        @(negedge clock);
        chk("hold_idle_busy", busy, 0);
        chk("hold_idle_results", err_count, 2);
        @(negedge clock);
        start = 1'b0;
        chk("hold_relaunch_busy", busy, 1);
        chk("hold_relaunch_addr", mem_addr, 0);
        chk("hold_cleared", {err_count, first_err_valid, first_err_addr}, 0);
        done_cyc = 0;
        for (int c = 2; c <= 60; c++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
        end
        chk("hold_second_done", done_cyc, 33);
        @(negedge clock);

        // Clean memory, with a stray start at cycle 10
        par_mem[2] = 1'b0;
        par_mem[6] = 1'b0;
        run_scan(1'b0, 10, 1'b0, 16);
        chk("clean_done_cycle", done_cyc, 33);
        chk("clean_addr_trace", addr_bad, 0);
        chk("clean_no_pulse", err_q.size(), 0);
        chk("clean_results", {err_count, first_err_valid, first_err_addr}, 0);
        @(negedge clock);
        chk("clean_single_done", {done, busy}, 0);
        @(negedge clock);
        chk("clean_no_relaunch", busy, 0);

        // Saturation on the 2-bit counter instance, every parity bit wrong
        @(negedge clock);
        start_s = 1'b1;
        @(negedge clock);
        start_s = 1'b0;
        pulses_s = 0;
        drop_s = 0;
        done_s_cyc = 0;
        saw3 = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (err_pulse_s === 1'b1) pulses_s++;
            if (saw3 && err_count_s !== 2'd3) drop_s++;
            if (err_count_s === 2'd3) saw3 = 1'b1;
            if (done_s === 1'b1) begin
                done_s_cyc = c;
                break;
            end
            @(negedge clock);
        end
        // The last pulse lands on the done cycle and was counted above.
        $display("saturation: done at cycle %0d, %0d pulses, err_count=%0d", done_s_cyc, pulses_s, err_count_s);
        chk("sat_done_cycle", done_s_cyc, 33);
        chk("sat_pulses", pulses_s, 16);
        chk("sat_count", err_count_s, 3);
        chk("sat_no_drop", drop_s, 0);
        chk("sat_first", {first_err_valid_s, first_err_addr_s}, 5'b1_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
